// File: rtl/rgb_pwm_gen_pkg.sv
// Shared LED constants and types, also used by the HSV-to-RGB converter.
package rgb_pwm_gen_pkg;

   localparam int DUTY_W = 8;
   localparam int CNT_W  = 8;
   localparam int PRE_W  = 16;

   typedef logic [DUTY_W-1:0] duty_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   localparam cnt_t CNT_LAST = {CNT_W{1'b1}};

   function automatic logic pwm_level(input cnt_t cnt, input duty_t duty);
      return (cnt < duty);
   endfunction

endpackage

// File: rtl/rgb_pwm_gen_pwm_channel.sv
// One PWM channel: shadow duty, active duty, compare against the period count, registered pin.
module pwm_channel
   import rgb_pwm_gen_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable_i,
   input  logic              load_i,
   input  logic              in_valid_i,
   input  logic [DUTY_W-1:0] duty_i,
   input  logic [CNT_W-1:0]  cnt_i,
   output logic              pwm_o
);

   duty_t shadow_q, shadow_d;
   duty_t active_q, active_d;
   logic  pwm_q, pwm_d;

   // Next-state: incoming write beats the shadow when both land on a load edge.
   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      pwm_d    = 1'b0;
      if (in_valid_i) begin
         shadow_d = duty_i;
      end else begin
         shadow_d = shadow_q;
      end
      if (load_i) begin
         active_d = shadow_d;
      end else begin
         active_d = active_q;
      end
      // The old active duty is used on the wrap edge so the last step stays glitch-free.
      if (enable_i) begin
         pwm_d = pwm_level(cnt_i, active_q);
      end else begin
         pwm_d = 1'b0;
      end
   end

   // Channel state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
         pwm_q    <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         pwm_q    <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel RGB LED PWM generator with a shared prescaled timebase and
// period-aligned (double-buffered) duty updates.
module rgb_pwm_gen
   import rgb_pwm_gen_pkg::*;
#(
   parameter int PRESCALE = 128
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       in_valid,
   input  logic [7:0] red_in,
   input  logic [7:0] green_in,
   input  logic [7:0] blue_in,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b,
   output logic       period_start,
   output logic       update_pending
);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

   logic [PRE_W-1:0] p_q, p_d;
   cnt_t             c_q, c_d;
   logic             ps_q, ps_d;
   logic             pend_q, pend_d;
   logic             step_s;
   logic             wrap_s;
   logic             load_s;

   assign step_s = (p_q == PRE_LAST);
   assign wrap_s = enable & step_s & (c_q == CNT_LAST);
   // While stopped the active duty tracks the shadow continuously.
   assign load_s = ~enable | wrap_s;

   // Timebase, period marker and pending-write flag next-state.
   always_comb begin
      p_d    = p_q;
      c_d    = c_q;
      ps_d   = 1'b0;
      pend_d = pend_q;
      if (!enable) begin
         p_d = '0;
         c_d = '0;
      end else if (step_s) begin
         p_d = '0;
         c_d = c_q + 8'd1;
      end else begin
         p_d = p_q + 16'd1;
         c_d = c_q;
      end
      ps_d = enable & (p_q == 16'd0) & (c_q == 8'd0);
      if (load_s) begin
         pend_d = 1'b0;
      end else if (in_valid) begin
         pend_d = 1'b1;
      end else begin
         pend_d = pend_q;
      end
   end

   // Timebase and status registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q    <= '0;
         c_q    <= '0;
         ps_q   <= 1'b0;
         pend_q <= 1'b0;
      end else begin
         p_q    <= p_d;
         c_q    <= c_d;
         ps_q   <= ps_d;
         pend_q <= pend_d;
      end
   end

   assign period_start   = ps_q;
   assign update_pending = pend_q;

   pwm_channel u_ch_r (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable),
      .load_i     (load_s),
      .in_valid_i (in_valid),
      .duty_i     (red_in),
      .cnt_i      (c_q),
      .pwm_o      (pwm_r)
   );

   pwm_channel u_ch_g (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable),
      .load_i     (load_s),
      .in_valid_i (in_valid),
      .duty_i     (green_in),
      .cnt_i      (c_q),
      .pwm_o      (pwm_g)
   );

   pwm_channel u_ch_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_i   (enable),
      .load_i     (load_s),
      .in_valid_i (in_valid),
      .duty_i     (blue_in),
      .cnt_i      (c_q),
      .pwm_o      (pwm_b)
   );

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Scoreboard bench: stimulus queues expected per-period high counts, a monitor
// measures each completed period between period_start pulses and compares.
module tb_rgb_pwm_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] red_in = 8'd0, green_in = 8'd0, blue_in = 8'd0;
   logic       pwm_r, pwm_g, pwm_b, period_start, update_pending;

   logic       en128 = 1'b0;
   logic       iv128 = 1'b0;
   logic [7:0] r128 = 8'd0, g128 = 8'd0, b128 = 8'd0;
   logic       pwm_r128, pwm_g128, pwm_b128, ps128, pend128;

   typedef struct {
      int r;
      int g;
      int b;
      int len;
   } exp_t;

   exp_t sb[$];
   bit   track = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   rgb_pwm_gen #(.PRESCALE(1)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
      .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
      .period_start(period_start), .update_pending(update_pending)
   );

   rgb_pwm_gen #(.PRESCALE(128)) dut128 (
      .clk(clk), .rst_n(rst_n), .enable(en128), .in_valid(iv128),
      .red_in(r128), .green_in(g128), .blue_in(b128),
      .pwm_r(pwm_r128), .pwm_g(pwm_g128), .pwm_b(pwm_b128),
      .period_start(ps128), .update_pending(pend128)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic write(input int r, input int g, input int b);
      red_in   = 8'(r);
      green_in = 8'(g);
      blue_in  = 8'(b);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic push_exp(input int r, input int g, input int b);
      exp_t e;
      e.r = r;
      e.g = g;
      e.b = b;
      e.len = 256;
      sb.push_back(e);
   endtask

   // Monitor: measure each period of the PRESCALE=1 instance.
   initial begin
      int   hr, hg, hb, len;
      bit   in_p;
      exp_t e;
      in_p = 1'b0;
      hr = 0; hg = 0; hb = 0; len = 0;
      forever begin
         @(negedge clk);
         if (!track) begin
            in_p = 1'b0;
         end else if (period_start) begin
            if (in_p) begin
               check("sb_has_entry", int'(sb.size() > 0), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  check("period_len", len, e.len);
                  check("high_r", hr, e.r);
                  check("high_g", hg, e.g);
                  check("high_b", hb, e.b);
               end
            end
            in_p = 1'b1;
            hr = int'(pwm_r); hg = int'(pwm_g); hb = int'(pwm_b); len = 1;
         end else if (in_p) begin
            hr += int'(pwm_r); hg += int'(pwm_g); hb += int'(pwm_b); len++;
         end
      end
   end

   initial begin
      int hr, hg, hb, len, k;

      // Reset state
      ticks(2);
      check("rst_pwm_r", int'(pwm_r), 0);
      check("rst_pwm_b", int'(pwm_b), 0);
      check("rst_period_start", int'(period_start), 0);
      check("rst_pending", int'(update_pending), 0);
      rst_n = 1'b1;
      ticks(2);

      // Basic duties; writes while stopped go straight to active
      write(64, 128, 255);
      check("stopped_pending", int'(update_pending), 0);
      check("stopped_pwm_g", int'(pwm_g), 0);
      push_exp(64, 128, 255);
      push_exp(64, 128, 255);
      track = 1'b1;
      enable = 1'b1;
      ticks(514);
      track = 1'b0;
      enable = 1'b0;
      ticks(2);

      // Mid-period write waits for the wrap
      write(50, 0, 0);
      push_exp(50, 0, 0);
      push_exp(200, 0, 0);
      track = 1'b1;
      enable = 1'b1;
      ticks(100);
      write(200, 0, 0);
      check("pend_after_write", int'(update_pending), 1);
      ticks(154);
      check("pend_before_wrap", int'(update_pending), 1);
      tick();
      check("pend_after_wrap", int'(update_pending), 0);
      ticks(258);
      track = 1'b0;
      enable = 1'b0;
      ticks(2);

      // Write landing exactly on the wrap edge
      write(30, 30, 30);
      push_exp(30, 30, 30);
      push_exp(10, 10, 10);
      track = 1'b1;
      enable = 1'b1;
      ticks(255);
      write(10, 10, 10);
      check("wrap_write_pending", int'(update_pending), 0);
      ticks(44);
      check("wrap_write_pending_later", int'(update_pending), 0);
      ticks(214);
      track = 1'b0;
      enable = 1'b0;
      ticks(2);

      // Asynchronous reset mid-period
      write(200, 200, 200);
      track = 1'b1;
      enable = 1'b1;
      ticks(130);
      check("pre_reset_pwm_r", int'(pwm_r), 1);
      #2;
      rst_n = 1'b0;
      track = 1'b0;
      #1;
      check("async_rst_pwm_r", int'(pwm_r), 0);
      check("async_rst_pwm_g", int'(pwm_g), 0);
      check("async_rst_pwm_b", int'(pwm_b), 0);
      ticks(3);
      rst_n = 1'b1;
      push_exp(0, 0, 0);
      track = 1'b1;
      tick();
      check("restart_period_start", int'(period_start), 1);
      check("restart_pwm_r", int'(pwm_r), 0);
      ticks(257);
      track = 1'b0;
      enable = 1'b0;
      ticks(2);

      // Enable rising after a write while stopped
      write(90, 90, 90);
      ticks(3);
      push_exp(90, 90, 90);
      track = 1'b1;
      enable = 1'b1;
      @(negedge clk);
      check("en_ps_before_edge", int'(period_start), 0);
      tick();
      check("en_ps_first_clk", int'(period_start), 1);
      tick();
      check("en_ps_second_clk", int'(period_start), 0);
      ticks(256);
      track = 1'b0;
      enable = 1'b0;
      ticks(2);
      check("sb_drained", sb.size(), 0);

      // PRESCALE=128 instance
      r128 = 8'd1;
      g128 = 8'd0;
      b128 = 8'd255;
      iv128 = 1'b1;
      tick();
      iv128 = 1'b0;
      check("p128_pending", int'(pend128), 0);
      en128 = 1'b1;
      k = 0;
      while (!ps128 && k < 10) begin
         tick();
         k++;
      end
      check("p128_first_start", int'(ps128), 1);
      hr = 0; hg = 0; hb = 0; len = 0;
      do begin
         hr += int'(pwm_r128);
         hg += int'(pwm_g128);
         hb += int'(pwm_b128);
         len++;
         tick();
      end while (!ps128 && len < 40000);
      check("p128_period_len", len, 32768);
      check("p128_high_r", hr, 128);
      check("p128_high_g", hg, 0);
      check("p128_high_b", hb, 32640);
      en128 = 1'b0;
      ticks(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
